// File: rtl/spi_out_pkg.sv
// spi_out_pkg: shared state encoding and word sizing for the SPI write-frame initiator.
package spi_out_pkg;
    typedef enum logic [2:0] {IDLE, SETUP, ADDR, DATA, TRAIL, GAP} state_t;
    localparam int WORD_BITS = 16;
    function automatic int clogb2(input int value);
        int r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction
    localparam int BIT_W = clogb2(WORD_BITS);
endpackage

// File: rtl/spi_out_sck_divider.sv
// spi_out_sck_divider: emits a one-cycle tick every CLK_DIV cycles while enabled,
// restarting its count whenever enable is low.
module spi_out_sck_divider #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CW = $clog2(CLK_DIV + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        tick  = en && (cnt_q == CW'(CLK_DIV - 1));
        cnt_d = (!en || tick) ? '0 : cnt_q + 1'b1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/spi_out.sv
// spi_out: SPI initiator emitting address/data write frames, merging consecutive
// addresses into one burst frame with a one-deep pending slot.
module spi_out
    import spi_out_pkg::*;
#(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int DATA_BUS_WIDTH    = 16,
    parameter int CLK_DIV           = 2,
    parameter int CS_IDLE           = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDRESS_BUS_WIDTH-1:0] address,
    input  logic [DATA_BUS_WIDTH-1:0]    data,
    input  logic                         write_valid,
    output logic                         write_ready,
    output logic                         cs,
    output logic                         sck,
    output logic                         mosi,
    output logic                         busy
);
    localparam int GW = $clog2(CS_IDLE + 1);
    localparam logic [BIT_W-1:0] TOP = BIT_W'(WORD_BITS - 1);
    state_t state_q, state_d;
    logic [ADDRESS_BUS_WIDTH-1:0] cur_addr_q, cur_addr_d, next_addr_q, next_addr_d, pend_addr, nxt_addr;
    logic [DATA_BUS_WIDTH-1:0] cur_data_q, cur_data_d, next_data_q, next_data_d, pend_data;
    logic next_full_q, next_full_d, cs_q, cs_d, sck_q, sck_d, mosi_q, mosi_d;
    logic write_ready_q, write_ready_d, busy_q, busy_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [GW-1:0] gap_q, gap_d;
    logic acc, take, pend, en, tick;

    spi_out_sck_divider #(.CLK_DIV(CLK_DIV)) u_div (.clk(clk), .rst(rst), .en(en), .tick(tick));

    always_comb begin
        en        = state_q inside {SETUP, ADDR, DATA, TRAIL};
        acc       = write_valid && write_ready_q;
        take      = acc && (state_q != IDLE);
        pend      = next_full_q || take;
        pend_addr = next_full_q ? next_addr_q : address;
        pend_data = next_full_q ? next_data_q : data;
        nxt_addr  = cur_addr_q + 1'b1;
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        cur_data_d  = cur_data_q;
        next_addr_d = take ? address : next_addr_q;
        next_data_d = take ? data : next_data_q;
        next_full_d = pend;
        bit_d       = bit_q;
        gap_d       = gap_q;
        cs_d        = cs_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        case (state_q)
            IDLE: if (acc) begin
                state_d    = SETUP;
                cur_addr_d = address;
                cur_data_d = data;
                cs_d       = 1'b0;
                mosi_d     = address[ADDRESS_BUS_WIDTH-1];
            end
            SETUP: if (tick) begin
                state_d = ADDR;
                sck_d   = 1'b1;
                bit_d   = TOP;
            end
            ADDR, DATA: if (tick) begin
                sck_d = !sck_q;
                if (sck_q) begin
                    if (bit_q != '0) begin
                        bit_d  = bit_q - 1'b1;
                        mosi_d = (state_q == ADDR) ? cur_addr_q[bit_d] : cur_data_q[bit_d];
                    end else if (state_q == ADDR) begin
                        state_d = DATA;
                        bit_d   = TOP;
                        mosi_d  = cur_data_q[DATA_BUS_WIDTH-1];
                    end else if (pend && pend_addr == nxt_addr) begin
                        cur_addr_d  = pend_addr;
                        cur_data_d  = pend_data;
                        next_full_d = 1'b0;
                        bit_d       = TOP;
                        mosi_d      = pend_data[DATA_BUS_WIDTH-1];
                    end else begin
                        state_d = TRAIL;
                        mosi_d  = 1'b0;
                        bit_d   = BIT_W'(1);
                    end
                end
            end
            // cs holds through the last bit's low phase plus one extra half-period
            TRAIL: if (tick) begin
                if (bit_q != '0) bit_d = bit_q - 1'b1;
                else begin
                    state_d = GAP;
                    cs_d    = 1'b1;
                    gap_d   = '0;
                end
            end
            GAP: if (gap_q == GW'(CS_IDLE - 1)) begin
                if (pend) begin
                    state_d     = SETUP;
                    cur_addr_d  = pend_addr;
                    cur_data_d  = pend_data;
                    next_full_d = 1'b0;
                    cs_d        = 1'b0;
                    mosi_d      = pend_addr[ADDRESS_BUS_WIDTH-1];
                end else state_d = IDLE;
            end else gap_d = gap_q + 1'b1;
            default: state_d = IDLE;
        endcase
        write_ready_d = !next_full_d;
        busy_d        = (state_d != IDLE) || next_full_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cur_addr_q    <= '0;
            cur_data_q    <= '0;
            next_addr_q   <= '0;
            next_data_q   <= '0;
            next_full_q   <= 1'b0;
            bit_q         <= '0;
            gap_q         <= '0;
            cs_q          <= 1'b1;
            sck_q         <= 1'b0;
            mosi_q        <= 1'b0;
            write_ready_q <= 1'b1;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= cur_addr_d;
            cur_data_q    <= cur_data_d;
            next_addr_q   <= next_addr_d;
            next_data_q   <= next_data_d;
            next_full_q   <= next_full_d;
            bit_q         <= bit_d;
            gap_q         <= gap_d;
            cs_q          <= cs_d;
            sck_q         <= sck_d;
            mosi_q        <= mosi_d;
            write_ready_q <= write_ready_d;
            busy_q        <= busy_d;
        end
    end

    assign cs          = cs_q;
    assign sck         = sck_q;
    assign mosi        = mosi_q;
    assign write_ready = write_ready_q;
    assign busy        = busy_q;
endmodule

// File: tb/tb_spi_out.sv
// tb_spi_out: directed vectors against an SPI receiver model that decodes frames
// and measures sck/cs timing.
`timescale 1ns/1ps
module tb_spi_out;
    localparam int CLK_DIV = 2;
    localparam int CS_IDLE = 2;

    logic clk = 1'b0, rst = 1'b1, write_valid = 1'b0;
    logic [15:0] address = '0, data = '0;
    logic write_ready, cs, sck, mosi, busy;
    int checks = 0, failures = 0, cyc = 0;

    spi_out #(.ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16), .CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk(clk), .rst(rst), .address(address), .data(data), .write_valid(write_valid),
        .write_ready(write_ready), .cs(cs), .sck(sck), .mosi(mosi), .busy(busy));

    always #5 clk = !clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] got_a[$], got_d[$], sr, cura;
    int hi_q[$];
    int frames, tr, rises, nb, fall_cyc, last_rise, mx, mn, cs_rise_cyc;
    int last_rises, last_low, last_mx, last_mn;
    logic cs_p, sck_p, have_a, seen;

    always @(negedge clk) begin
        if (rst) begin
            got_a.delete(); got_d.delete(); hi_q.delete();
            frames = 0; tr = 0; rises = 0; nb = 0; seen = 0; have_a = 0;
        end else begin
            if (cs_p && !cs) begin
                if (seen) hi_q.push_back(cyc - cs_rise_cyc);
                fall_cyc = cyc; nb = 0; rises = 0; have_a = 0; mx = 0; mn = 1000;
            end
            if (!cs && sck && !sck_p) begin
                if (rises > 0) begin
                    if (cyc - last_rise > mx) mx = cyc - last_rise;
                    if (cyc - last_rise < mn) mn = cyc - last_rise;
                end
                last_rise = cyc; rises++; tr++;
                sr = {sr[14:0], mosi}; nb++;
                if (nb == 16) begin
                    nb = 0;
                    if (!have_a) begin cura = sr; have_a = 1; end
                    else begin got_a.push_back(cura); got_d.push_back(sr); cura = cura + 1'b1; end
                end
            end
            if (!cs_p && cs) begin
                frames++; last_rises = rises; last_low = cyc - fall_cyc;
                last_mx = mx; last_mn = mn; cs_rise_cyc = cyc; seen = 1;
            end
        end
        cs_p = cs; sck_p = sck;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d, output int waited);
        address = a; data = d; write_valid = 1'b1; waited = 0;
        while (!write_ready && waited < 2000) begin @(negedge clk); waited++; end
        chk("push_ready", write_ready, 1);
        @(negedge clk);
        write_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((busy || !cs) && t < 20000) begin @(negedge clk); t++; end
        chk("idle_reached", busy, 0);
        chk("busy_drop", cyc - cs_rise_cyc, CS_IDLE);
    endtask

    typedef struct {
        int n;
        logic [2:0][15:0] a;
        logic [2:0][15:0] d;
        int frames;
        int rises;
    } vec_t;

    function automatic vec_t mk(int n, logic [15:0] a0, d0, a1, d1, a2, d2, int fr, int ri);
        vec_t v;
        v.n = n; v.a[0] = a0; v.d[0] = d0; v.a[1] = a1; v.d[1] = d1; v.a[2] = a2; v.d[2] = d2;
        v.frames = fr; v.rises = ri;
        return v;
    endfunction

    initial begin #1_000_000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

    initial begin
        vec_t vecs[5];
        int w, fb, qb, hb, t0;
        vecs[0] = mk(1, 16'h1234, 16'hABCD, 16'h0, 16'h0, 16'h0, 16'h0, 1, 32);
        vecs[1] = mk(3, 16'h0010, 16'h1111, 16'h0011, 16'h2222, 16'h0012, 16'h3333, 1, 64);
        vecs[2] = mk(2, 16'h0010, 16'hAAAA, 16'h0020, 16'h5555, 16'h0, 16'h0, 2, 32);
        vecs[3] = mk(2, 16'hFFFF, 16'h0F0F, 16'h0000, 16'hF0F0, 16'h0, 16'h0, 1, 48);
        vecs[4] = mk(3, 16'h0050, 16'h1357, 16'h0060, 16'h2468, 16'h0070, 16'h9ABC, 3, 32);
        repeat (3) @(negedge clk);
        chk("rst_cs", cs, 1); chk("rst_sck", sck, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("init_cs", cs, 1); chk("init_sck", sck, 0); chk("init_mosi", mosi, 0);
        chk("init_ready", write_ready, 1); chk("init_busy", busy, 0);

        for (int i = 0; i < 5; i++) begin
            fb = frames; qb = got_a.size(); hb = hi_q.size();
            for (int k = 0; k < vecs[i].n; k++) push(vecs[i].a[k], vecs[i].d[k], w);
            wait_idle();
            chk($sformatf("v%0d_frames", i), frames - fb, vecs[i].frames);
            chk($sformatf("v%0d_nwrites", i), got_a.size() - qb, vecs[i].n);
            for (int k = 0; k < vecs[i].n; k++)
                if (qb + k < got_a.size()) begin
                    chk($sformatf("v%0d_addr%0d", i, k), got_a[qb + k], vecs[i].a[k]);
                    chk($sformatf("v%0d_data%0d", i, k), got_d[qb + k], vecs[i].d[k]);
                end
            chk($sformatf("v%0d_rises", i), last_rises, vecs[i].rises);
            chk($sformatf("v%0d_cs_low", i), last_low, 2 * vecs[i].rises * CLK_DIV + 2 * CLK_DIV);
            chk($sformatf("v%0d_rise_max", i), last_mx, 2 * CLK_DIV);
            chk($sformatf("v%0d_rise_min", i), last_mn, 2 * CLK_DIV);
            for (int j = hb; j < hi_q.size(); j++) chk($sformatf("v%0d_cs_high", i), hi_q[j] >= CS_IDLE, 1);
            repeat (3) @(negedge clk);
        end

        // backpressure: third request waits for the word-end merge to free next
        fb = frames; qb = got_a.size();
        push(16'h0040, 16'hC001, w);
        push(16'h0041, 16'hC002, w);
        chk("bp_ready_low", write_ready, 0);
        push(16'h0042, 16'hC003, w);
        chk("bp_wait", w, 127);
        wait_idle();
        chk("bp_frames", frames - fb, 1);
        chk("bp_rises", last_rises, 64);
        chk("bp_nwrites", got_a.size() - qb, 3);
        for (int k = 0; k < 3; k++)
            if (qb + k < got_a.size()) begin
                chk($sformatf("bp_addr%0d", k), got_a[qb + k], 16'h0040 + 16'(k));
                chk($sformatf("bp_data%0d", k), got_d[qb + k], 16'hC001 + 16'(k));
            end

        // reset mid-frame with a request pending
        repeat (3) @(negedge clk);
        t0 = tr;
        push(16'h0100, 16'h0BAD, w);
        push(16'h0300, 16'h0BAD, w);
        w = 0;
        while (tr < t0 + 10 && w < 1000) begin @(negedge clk); w++; end
        chk("mid_rises", tr >= t0 + 10, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", cs, 1); chk("mid_rst_sck", sck, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", write_ready, 1); chk("post_rst_busy", busy, 0);
        push(16'h0001, 16'h0055, w);
        wait_idle();
        chk("post_rst_nwrites", got_a.size(), 1);
        chk("post_rst_addr", got_a.size() > 0 ? 32'(got_a[0]) : 32'hDEAD, 32'h0001);
        chk("post_rst_data", got_d.size() > 0 ? 32'(got_d[0]) : 32'hDEAD, 32'h0055);
        chk("post_rst_rises", last_rises, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
